// File: rtl/core_mem_port_arb_pkg.sv
// ============================================================================
// Module   : core_mem_port_arb_pkg
// Brief    : Shared types and constants for the core data-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_mem_port_arb_pkg;

  localparam int   CORE_XLEN    = 32;
  localparam logic ARB_PORT_IFU = 1'b0;
  localparam logic ARB_PORT_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/core_rr_arb2.sv
// ============================================================================
// Module   : core_rr_arb2
// Brief    : Two-way round-robin picker; on a tie the port not granted last wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_rr_arb2
  import core_mem_port_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || (last_grant == ARB_PORT_LSU))) begin
      grant[0] = 1'b1;
    end else if (req[1]) begin
      grant[1] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_mem_port_arb.sv
// ============================================================================
// Module   : core_mem_port_arb
// Brief    : Shares one data-memory port between IFU (p0) and LSU (p1), single
//            outstanding access, round-robin grant, watchdog abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_mem_port_arb
  import core_mem_port_arb_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int WMASK_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_req_valid,
  output logic               p0_req_ready,
  input  logic [XLEN-1:0]    p0_req_addr,
  output logic               p0_resp_valid,
  output logic [XLEN-1:0]    p0_resp_rdata,
  output logic               p0_resp_err,
  input  logic               p1_req_valid,
  output logic               p1_req_ready,
  input  logic [XLEN-1:0]    p1_req_addr,
  input  logic               p1_req_wen,
  input  logic [XLEN-1:0]    p1_req_wdata,
  input  logic [WMASK_W-1:0] p1_req_wmask,
  output logic               p1_resp_valid,
  output logic [XLEN-1:0]    p1_resp_rdata,
  output logic               p1_resp_err,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XLEN-1:0]    mem_addr,
  output logic               mem_wen,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [WMASK_W-1:0] mem_wmask,
  input  logic               mem_resp_valid,
  input  logic [XLEN-1:0]    mem_rdata
);

  localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic            c_wdog_en  = (TIMEOUT > 0);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_owner;
  logic               r_last_grant;
  logic [XLEN-1:0]    r_addr;
  logic               r_wen;
  logic [XLEN-1:0]    r_wdata;
  logic [WMASK_W-1:0] r_wmask;

  logic [1:0]         w_grant;
  logic               w_take;
  logic               w_abort;
  logic               w_resp_fire;
  logic               w_resp_err;
  logic [XLEN-1:0]    w_rdata;

  core_rr_arb2 u_rr (
    .req        ({p1_req_valid, p0_req_valid}),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // Abort fires on the TIMEOUT-th cycle spent in the current busy state.
  assign w_abort = c_wdog_en && (r_state != ST_IDLE) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    w_take        = 1'b0;
    w_resp_fire   = 1'b0;
    w_resp_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        p0_req_ready = w_grant[0];
        p1_req_ready = w_grant[1];
        if (|w_grant) begin
          w_take      = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_abort) begin
          w_resp_fire = 1'b1;
          w_resp_err  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        // A real response arriving on the abort cycle still wins.
        if (mem_resp_valid) begin
          w_resp_fire = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_abort) begin
          w_resp_fire = 1'b1;
          w_resp_err  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_owner      <= ARB_PORT_IFU;
      r_last_grant <= ARB_PORT_LSU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (c_wdog_en && (r_state != ST_IDLE)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_take) begin
        r_owner      <= w_grant[1];
        r_last_grant <= w_grant[1];
        r_addr       <= w_grant[1] ? p1_req_addr : p0_req_addr;
        r_wen        <= w_grant[1] & p1_req_wen;
        r_wdata      <= w_grant[1] ? p1_req_wdata : '0;
        r_wmask      <= w_grant[1] ? p1_req_wmask : '0;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wen   = r_wen;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;

  assign w_rdata = (w_resp_err || r_wen) ? '0 : mem_rdata;

  assign p0_resp_valid = w_resp_fire && (r_owner == ARB_PORT_IFU);
  assign p1_resp_valid = w_resp_fire && (r_owner == ARB_PORT_LSU);
  assign p0_resp_rdata = p0_resp_valid ? w_rdata : '0;
  assign p1_resp_rdata = p1_resp_valid ? w_rdata : '0;
  assign p0_resp_err   = p0_resp_valid & w_resp_err;
  assign p1_resp_err   = p1_resp_valid & w_resp_err;

endmodule

`default_nettype wire
